clk_period_meter: RTL

//  Receive-side counterpart of the clock divider: samples a slow divided-clock/tick signal in the clk domain,

---
 rtl/clk_meas_pkg.sv | 19 +
 rtl/sync_edge_detect.sv | 41 ++++
 rtl/clk_period_meter.sv | 142 ++++++++++++++
 3 files changed

// File: rtl/clk_meas_pkg.sv
// rtl/clk_meas_pkg.sv - shared state encodings and default constants for the clock period meter
//
// Purpose: FSM state type and default parameter values used by clk_period_meter.
// Ports: none (package).

package clk_meas_pkg;

    localparam int DEF_CNT_W      = 8;
    localparam int DEF_TIMEOUT    = 255;
    localparam int DEF_LOCK_COUNT = 4;

    typedef enum logic [1:0] {
        ST_SEARCH  = 2'd0,
        ST_MEASURE = 2'd1,
        ST_TRACK   = 2'd2,
        ST_LOCKED  = 2'd3
    } meas_state_t;

endpackage

// File: rtl/sync_edge_detect.sv
// rtl/sync_edge_detect.sv - two-flop synchroniser with registered rise/fall strobes
//
// Purpose: bring an asynchronous level into the clk domain and flag its edges.
// Ports:
//   clk        in   system clock
//   reset_n    in   asynchronous active-low reset
//   sig_in     in   asynchronous level to observe
//   rise_pulse out  one-cycle strobe per detected rising edge
//   fall_pulse out  one-cycle strobe per detected falling edge

module sync_edge_detect (
    input  logic clk,
    input  logic reset_n,
    input  logic sig_in,
    output logic rise_pulse,
    output logic fall_pulse
);

    logic s1;
    logic s2;
    logic s3;

    // s1/s2 form the synchroniser, s3 is history; strobes are registered,
    // so an input change shows on the strobe three edges after first sampling.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            s1         <= 1'b0;
            s2         <= 1'b0;
            s3         <= 1'b0;
            rise_pulse <= 1'b0;
            fall_pulse <= 1'b0;
        end else begin
            s1         <= sig_in;
            s2         <= s1;
            s3         <= s2;
            rise_pulse <= s2 & ~s3;
            fall_pulse <= ~s2 & s3;
        end
    end

endmodule

// File: rtl/clk_period_meter.sv
// rtl/clk_period_meter.sv - measures period and high time of a slow clock/tick, reports lock and loss
//
// Purpose: synchronise sig_in, measure rise-to-rise period and rise-to-fall high time
//          in clk cycles, assert locked after LOCK_COUNT consecutive equal periods,
//          and flag loss of signal after TIMEOUT cycles without a rise.
// Ports:
//   clk         in   system clock
//   reset_n     in   asynchronous active-low reset
//   sig_in      in   asynchronous divided clock / tick
//   rise_pulse  out  strobe per detected rising edge
//   fall_pulse  out  strobe per detected falling edge
//   period      out  last measured period (clk cycles)
//   high_time   out  last measured high time (clk cycles)
//   meas_valid  out  strobe when period/high_time update
//   locked      out  period stable
//   timeout_err out  strobe when signal is declared lost

module clk_period_meter
    import clk_meas_pkg::*;
#(
    parameter int CNT_W      = DEF_CNT_W,
    parameter int TIMEOUT    = DEF_TIMEOUT,
    parameter int LOCK_COUNT = DEF_LOCK_COUNT
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             sig_in,
    output logic             rise_pulse,
    output logic             fall_pulse,
    output logic [CNT_W-1:0] period,
    output logic [CNT_W-1:0] high_time,
    output logic             meas_valid,
    output logic             locked,
    output logic             timeout_err
);

    localparam logic [CNT_W-1:0] CNT_MAX   = '1;
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
    localparam logic [CNT_W-1:0] TIMEOUT_V = CNT_W'(TIMEOUT);
    localparam logic [CNT_W-1:0] LOCK_V    = CNT_W'(LOCK_COUNT);

    meas_state_t      state;
    logic [CNT_W-1:0] run_cnt;
    logic [CNT_W-1:0] ref_period;
    logic [CNT_W-1:0] match_cnt;

    logic             timeout_hit;
    logic             period_match;
    logic [CNT_W-1:0] match_next;

    sync_edge_detect u_sync (
        .clk        (clk),
        .reset_n    (reset_n),
        .sig_in     (sig_in),
        .rise_pulse (rise_pulse),
        .fall_pulse (fall_pulse)
    );

    // A rise landing on the timeout cycle takes precedence.
    assign timeout_hit  = (state != ST_SEARCH) && (run_cnt == TIMEOUT_V) && !rise_pulse;
    assign period_match = (run_cnt == ref_period);
    assign match_next   = match_cnt + CNT_ONE;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state       <= ST_SEARCH;
            run_cnt     <= '0;
            ref_period  <= '0;
            match_cnt   <= '0;
            period      <= '0;
            high_time   <= '0;
            meas_valid  <= 1'b0;
            locked      <= 1'b0;
            timeout_err <= 1'b0;
        end else begin
            meas_valid  <= 1'b0;
            timeout_err <= 1'b0;

            // The rise cycle itself is the first counted cycle, so run_cnt read
            // on the next rise equals the exact rise-to-rise distance.
            if (rise_pulse) begin
                run_cnt <= CNT_ONE;
            end else if (run_cnt != CNT_MAX) begin
                run_cnt <= run_cnt + CNT_ONE;
            end

            if (fall_pulse && (state != ST_SEARCH)) begin
                high_time <= run_cnt;
            end

            if (timeout_hit) begin
                timeout_err <= 1'b1;
                locked      <= 1'b0;
                period      <= '0;
                high_time   <= '0;
                match_cnt   <= '0;
                state       <= ST_SEARCH;
            end else if (rise_pulse) begin
                case (state)
                    ST_SEARCH: begin
                        state <= ST_MEASURE;
                    end
                    ST_MEASURE: begin
                        period     <= run_cnt;
                        meas_valid <= 1'b1;
                        ref_period <= run_cnt;
                        match_cnt  <= '0;
                        state      <= ST_TRACK;
                    end
                    ST_TRACK: begin
                        period     <= run_cnt;
                        meas_valid <= 1'b1;
                        if (period_match) begin
                            match_cnt <= match_next;
                            if (match_next == LOCK_V) begin
                                locked <= 1'b1;
                                state  <= ST_LOCKED;
                            end
                        end else begin
                            ref_period <= run_cnt;
                            match_cnt  <= '0;
                        end
                    end
                    ST_LOCKED: begin
                        period     <= run_cnt;
                        meas_valid <= 1'b1;
                        if (!period_match) begin
                            ref_period <= run_cnt;
                            match_cnt  <= '0;
                            locked     <= 1'b0;
                            state      <= ST_TRACK;
                        end
                    end
                    default: begin
                        state <= ST_SEARCH;
                    end
                endcase
            end
        end
    end

endmodule
